// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared constants and IF/ID bundle type for the fetch stage
package if_fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int IFID_PC_W   = XLEN;
    localparam int IFID_INST_W = 32;

    localparam logic [XLEN-1:0]        RESET_PC_DEF = 32'h0000_0000;
    localparam logic [IFID_INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

    typedef struct packed {
        logic                   valid;
        logic [IFID_PC_W-1:0]   pc;
        logic [IFID_PC_W-1:0]   pc4;
        logic [IFID_INST_W-1:0] inst;
    } ifid_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_unit_skid.sv
// rtl/if_fetch_unit_skid.sv - one-entry holding register for a ROM response that lands during a stall
module fetch_skid_buf
    import if_fetch_unit_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   load_i,
    input  logic                   clear_i,
    input  logic                   consume_i,
    input  logic [IFID_PC_W-1:0]   pc_i,
    input  logic [IFID_INST_W-1:0] inst_i,
    output logic                   valid_o,
    output logic [IFID_PC_W-1:0]   pc_o,
    output logic [IFID_INST_W-1:0] inst_o
);

    logic                   valid_q;
    logic [IFID_PC_W-1:0]   pc_q;
    logic [IFID_INST_W-1:0] inst_q;

    // clear beats load: a flush must drop the response that arrives with it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end else if (consume_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - fetch PC generation, 1-cycle ROM interface and IF/ID register
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0]        RESET_PC = RESET_PC_DEF,
    parameter logic [IFID_INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst_n,
    input  logic                   stall_i,
    input  logic                   redirect_i,
    input  logic [XLEN-1:0]        redirect_pc_i,
    output logic                   irom_req_o,
    output logic [XLEN-1:0]        irom_addr_o,
    input  logic [IFID_INST_W-1:0] irom_inst_i,
    output logic                   id_valid_o,
    output logic [IFID_PC_W-1:0]   id_pc_o,
    output logic [IFID_PC_W-1:0]   id_pc4_o,
    output logic [IFID_INST_W-1:0] id_inst_o
);

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [XLEN-1:0]        inflight_pc_q;
    logic                   inflight_q;
    ifid_t                  id_q, id_d;
    logic                   fetch_go;
    logic                   skid_valid;
    logic [IFID_PC_W-1:0]   skid_pc;
    logic [IFID_INST_W-1:0] skid_inst;

    assign fetch_go    = !stall_i && !redirect_i;
    assign irom_req_o  = cpu_rst_n && fetch_go;
    assign irom_addr_o = pc_q;

    fetch_skid_buf u_skid (
        .clk_i     (cpu_clk),
        .rst_ni    (cpu_rst_n),
        .load_i    (inflight_q && stall_i && !redirect_i),
        .clear_i   (redirect_i),
        .consume_i (fetch_go),
        .pc_i      (inflight_pc_q),
        .inst_i    (irom_inst_i),
        .valid_o   (skid_valid),
        .pc_o      (skid_pc),
        .inst_o    (skid_inst)
    );

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = align_word(redirect_pc_i);
        end else if (fetch_go) begin
            pc_d = pc_q + 32'd4;
        end
    end

    // Skid data is older than any live response, so it drains first on release.
    always_comb begin
        id_d = id_q;
        if (redirect_i) begin
            id_d.valid = 1'b0;
            id_d.inst  = NOP_INST;
        end else if (!stall_i) begin
            if (skid_valid) begin
                id_d = '{valid: 1'b1, pc: skid_pc, pc4: skid_pc + 32'd4, inst: skid_inst};
            end else if (inflight_q) begin
                id_d = '{valid: 1'b1, pc: inflight_pc_q, pc4: inflight_pc_q + 32'd4,
                         inst: irom_inst_i};
            end else begin
                id_d.valid = 1'b0;
                id_d.inst  = NOP_INST;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            id_q          <= '{valid: 1'b0, pc: '0, pc4: '0, inst: NOP_INST};
        end else begin
            pc_q       <= pc_d;
            inflight_q <= fetch_go;
            if (fetch_go) begin
                inflight_pc_q <= pc_q;
            end
            id_q <= id_d;
        end
    end

    assign id_valid_o = id_q.valid;
    assign id_pc_o    = id_q.pc;
    assign id_pc4_o   = id_q.pc4;
    assign id_inst_o  = id_q.inst;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0;
    logic        irom_req_o;
    logic [31:0] irom_addr_o;
    logic [31:0] irom_inst_i = 32'h0;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_pc4_o;
    logic [31:0] id_inst_o;

    int checks = 0;
    int failures = 0;

    if_fetch_unit dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst_n     (cpu_rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .irom_req_o    (irom_req_o),
        .irom_addr_o   (irom_addr_o),
        .irom_inst_i   (irom_inst_i),
        .id_valid_o    (id_valid_o),
        .id_pc_o       (id_pc_o),
        .id_pc4_o      (id_pc4_o),
        .id_inst_o     (id_inst_o)
    );

    always #5 cpu_clk = ~cpu_clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    always @(posedge cpu_clk) begin
        if (irom_req_o) irom_inst_i <= rom(irom_addr_o);
    end

    task automatic next_cycle();
        @(posedge cpu_clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: first interval after reset release.
    task automatic do_reset();
        cpu_rst_n = 1'b0;
        stall_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = 32'h0;
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cpu_rst_n = 1'b0;
        @(posedge cpu_clk);
        #2;
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL reset id_valid got=%b exp=0", id_valid_o); end
        checks++; if (id_pc_o !== 32'h0) begin failures++; $display("FAIL reset id_pc got=%h exp=0", id_pc_o); end
        checks++; if (id_pc4_o !== 32'h0) begin failures++; $display("FAIL reset id_pc4 got=%h exp=0", id_pc4_o); end
        checks++; if (id_inst_o !== NOP) begin failures++; $display("FAIL reset id_inst got=%h exp=%h", id_inst_o, NOP); end
        checks++; if (irom_req_o !== 1'b0) begin failures++; $display("FAIL reset irom_req got=%b exp=0", irom_req_o); end
        checks++; if (irom_addr_o !== 32'h0) begin failures++; $display("FAIL reset irom_addr got=%h exp=0", irom_addr_o); end
    endtask

    task automatic test_release();
        logic [31:0] ep;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            #2;
            ep = 32'(4 * (c - 2));
            checks++; if (irom_req_o !== 1'b1) begin failures++; $display("FAIL release c%0d irom_req got=%b exp=1", c, irom_req_o); end
            checks++; if (irom_addr_o !== 32'(4 * c)) begin failures++; $display("FAIL release c%0d irom_addr got=%h exp=%h", c, irom_addr_o, 32'(4 * c)); end
            checks++; if (id_valid_o !== (c >= 2)) begin failures++; $display("FAIL release c%0d id_valid got=%b exp=%b", c, id_valid_o, c >= 2); end
            if (c >= 2) begin
                checks++; if (id_pc_o !== ep) begin failures++; $display("FAIL release c%0d id_pc got=%h exp=%h", c, id_pc_o, ep); end
                checks++; if (id_pc4_o !== ep + 32'd4) begin failures++; $display("FAIL release c%0d id_pc4 got=%h exp=%h", c, id_pc4_o, ep + 32'd4); end
                checks++; if (id_inst_o !== rom(ep)) begin failures++; $display("FAIL release c%0d id_inst got=%h exp=%h", c, id_inst_o, rom(ep)); end
            end else begin
                checks++; if (id_inst_o !== NOP) begin failures++; $display("FAIL release c%0d id_inst got=%h exp=%h", c, id_inst_o, NOP); end
            end
        end
    endtask

    task automatic test_single_stall();
        logic        st [8] = '{0,0,0,1,0,0,0,0};
        logic [31:0] ea [8] = '{0,4,8,12,12,16,20,24};
        logic        er [8] = '{1,1,1,0,1,1,1,1};
        logic        ev [8] = '{0,0,1,1,1,1,1,1};
        logic [31:0] ep [8] = '{0,0,0,4,4,8,12,16};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) next_cycle();
            stall_i = st[c];
            #2;
            checks++; if (irom_req_o !== er[c]) begin failures++; $display("FAIL single_stall c%0d irom_req got=%b exp=%b", c, irom_req_o, er[c]); end
            checks++; if (irom_addr_o !== ea[c]) begin failures++; $display("FAIL single_stall c%0d irom_addr got=%h exp=%h", c, irom_addr_o, ea[c]); end
            checks++; if (id_valid_o !== ev[c]) begin failures++; $display("FAIL single_stall c%0d id_valid got=%b exp=%b", c, id_valid_o, ev[c]); end
            if (ev[c]) begin
                checks++; if (id_pc_o !== ep[c]) begin failures++; $display("FAIL single_stall c%0d id_pc got=%h exp=%h", c, id_pc_o, ep[c]); end
                checks++; if (id_inst_o !== rom(ep[c])) begin failures++; $display("FAIL single_stall c%0d id_inst got=%h exp=%h", c, id_inst_o, rom(ep[c])); end
            end
        end
        stall_i = 1'b0;
    endtask

    task automatic test_long_stall();
        logic        st [13] = '{0,0,0,0,1,1,1,1,1,0,0,0,0};
        logic [31:0] ea [13] = '{0,4,8,12,16,16,16,16,16,16,20,24,28};
        logic [31:0] ep [13] = '{0,0,0,4,8,8,8,8,8,8,12,16,20};
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c > 0) next_cycle();
            stall_i = st[c];
            #2;
            checks++; if (irom_req_o !== !st[c]) begin failures++; $display("FAIL long_stall c%0d irom_req got=%b exp=%b", c, irom_req_o, !st[c]); end
            checks++; if (irom_addr_o !== ea[c]) begin failures++; $display("FAIL long_stall c%0d irom_addr got=%h exp=%h", c, irom_addr_o, ea[c]); end
            checks++; if (id_valid_o !== (c >= 2)) begin failures++; $display("FAIL long_stall c%0d id_valid got=%b exp=%b", c, id_valid_o, c >= 2); end
            if (c >= 2) begin
                checks++; if (id_pc_o !== ep[c]) begin failures++; $display("FAIL long_stall c%0d id_pc got=%h exp=%h", c, id_pc_o, ep[c]); end
                checks++; if (id_pc4_o !== ep[c] + 32'd4) begin failures++; $display("FAIL long_stall c%0d id_pc4 got=%h exp=%h", c, id_pc4_o, ep[c] + 32'd4); end
            end
        end
        stall_i = 1'b0;
    endtask

    task automatic test_redirect();
        logic        rd [10] = '{0,0,0,0,0,1,0,0,0,0};
        logic [31:0] ea [10] = '{0,4,8,12,16,20,32'h100,32'h104,32'h108,32'h10C};
        logic        er [10] = '{1,1,1,1,1,0,1,1,1,1};
        logic        ev [10] = '{0,0,1,1,1,1,0,0,1,1};
        logic [31:0] ep [10] = '{0,0,0,4,8,12,0,0,32'h100,32'h104};
        do_reset();
        redirect_pc_i = 32'h0000_0100;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) next_cycle();
            redirect_i = rd[c];
            #2;
            checks++; if (irom_req_o !== er[c]) begin failures++; $display("FAIL redirect c%0d irom_req got=%b exp=%b", c, irom_req_o, er[c]); end
            checks++; if (irom_addr_o !== ea[c]) begin failures++; $display("FAIL redirect c%0d irom_addr got=%h exp=%h", c, irom_addr_o, ea[c]); end
            checks++; if (id_valid_o !== ev[c]) begin failures++; $display("FAIL redirect c%0d id_valid got=%b exp=%b", c, id_valid_o, ev[c]); end
            if (ev[c]) begin
                checks++; if (id_pc_o !== ep[c]) begin failures++; $display("FAIL redirect c%0d id_pc got=%h exp=%h", c, id_pc_o, ep[c]); end
                checks++; if (id_inst_o !== rom(ep[c])) begin failures++; $display("FAIL redirect c%0d id_inst got=%h exp=%h", c, id_inst_o, rom(ep[c])); end
            end else begin
                checks++; if (id_inst_o !== NOP) begin failures++; $display("FAIL redirect c%0d id_inst got=%h exp=%h", c, id_inst_o, NOP); end
            end
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_redirect_stall();
        logic        st [9] = '{0,0,0,1,1,0,0,0,0};
        logic        rd [9] = '{0,0,0,0,1,0,0,0,0};
        logic [31:0] ea [9] = '{0,4,8,12,12,32'h100,32'h104,32'h108,32'h10C};
        logic        er [9] = '{1,1,1,0,0,1,1,1,1};
        logic        ev [9] = '{0,0,1,1,1,0,0,1,1};
        logic [31:0] ep [9] = '{0,0,0,4,4,0,0,32'h100,32'h104};
        do_reset();
        redirect_pc_i = 32'h0000_0103;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) next_cycle();
            stall_i = st[c];
            redirect_i = rd[c];
            #2;
            checks++; if (irom_req_o !== er[c]) begin failures++; $display("FAIL redir_stall c%0d irom_req got=%b exp=%b", c, irom_req_o, er[c]); end
            checks++; if (irom_addr_o !== ea[c]) begin failures++; $display("FAIL redir_stall c%0d irom_addr got=%h exp=%h", c, irom_addr_o, ea[c]); end
            checks++; if (id_valid_o !== ev[c]) begin failures++; $display("FAIL redir_stall c%0d id_valid got=%b exp=%b", c, id_valid_o, ev[c]); end
            if (ev[c]) begin
                checks++; if (id_pc_o !== ep[c]) begin failures++; $display("FAIL redir_stall c%0d id_pc got=%h exp=%h", c, id_pc_o, ep[c]); end
                checks++; if (id_pc4_o !== ep[c] + 32'd4) begin failures++; $display("FAIL redir_stall c%0d id_pc4 got=%h exp=%h", c, id_pc4_o, ep[c] + 32'd4); end
            end
        end
        stall_i = 1'b0;
        redirect_i = 1'b0;
    endtask

    task automatic test_pc_wrap();
        logic        rd [7] = '{0,1,0,0,0,0,0};
        logic [31:0] ea [7] = '{0,4,32'hFFFF_FFFC,0,4,8,12};
        logic        er [7] = '{1,0,1,1,1,1,1};
        logic        ev [7] = '{0,0,0,0,1,1,1};
        logic [31:0] ep [7] = '{0,0,0,0,32'hFFFF_FFFC,0,4};
        do_reset();
        redirect_pc_i = 32'hFFFF_FFFC;
        for (int c = 0; c < 7; c++) begin
            if (c > 0) next_cycle();
            redirect_i = rd[c];
            #2;
            checks++; if (irom_req_o !== er[c]) begin failures++; $display("FAIL pc_wrap c%0d irom_req got=%b exp=%b", c, irom_req_o, er[c]); end
            checks++; if (irom_addr_o !== ea[c]) begin failures++; $display("FAIL pc_wrap c%0d irom_addr got=%h exp=%h", c, irom_addr_o, ea[c]); end
            checks++; if (id_valid_o !== ev[c]) begin failures++; $display("FAIL pc_wrap c%0d id_valid got=%b exp=%b", c, id_valid_o, ev[c]); end
            if (ev[c]) begin
                checks++; if (id_pc_o !== ep[c]) begin failures++; $display("FAIL pc_wrap c%0d id_pc got=%h exp=%h", c, id_pc_o, ep[c]); end
                checks++; if (id_pc4_o !== ep[c] + 32'd4) begin failures++; $display("FAIL pc_wrap c%0d id_pc4 got=%h exp=%h", c, id_pc4_o, ep[c] + 32'd4); end
            end
        end
        redirect_i = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [31:0] ep;
        do_reset();
        for (int c = 1; c < 5; c++) begin
            next_cycle();
            stall_i = (c >= 3);
        end
        #2;
        checks++; if (id_valid_o !== 1'b1 || id_pc_o !== 32'h4) begin failures++; $display("FAIL rst_mid pre id_valid=%b id_pc got=%h exp valid=1 pc=4", id_valid_o, id_pc_o); end
        cpu_rst_n = 1'b0;
        #1;
        checks++; if (id_valid_o !== 1'b0) begin failures++; $display("FAIL rst_mid id_valid got=%b exp=0", id_valid_o); end
        checks++; if (id_pc_o !== 32'h0 || id_pc4_o !== 32'h0) begin failures++; $display("FAIL rst_mid id_pc/pc4 got=%h/%h exp=0/0", id_pc_o, id_pc4_o); end
        checks++; if (id_inst_o !== NOP) begin failures++; $display("FAIL rst_mid id_inst got=%h exp=%h", id_inst_o, NOP); end
        checks++; if (irom_req_o !== 1'b0 || irom_addr_o !== 32'h0) begin failures++; $display("FAIL rst_mid irom req/addr got=%b/%h exp=0/0", irom_req_o, irom_addr_o); end
        stall_i = 1'b0;
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) next_cycle();
            #2;
            ep = 32'(4 * (c - 2));
            checks++; if (irom_addr_o !== 32'(4 * c)) begin failures++; $display("FAIL rst_mid_restart c%0d irom_addr got=%h exp=%h", c, irom_addr_o, 32'(4 * c)); end
            checks++; if (id_valid_o !== (c >= 2)) begin failures++; $display("FAIL rst_mid_restart c%0d id_valid got=%b exp=%b", c, id_valid_o, c >= 2); end
            if (c >= 2) begin
                checks++; if (id_pc_o !== ep || id_inst_o !== rom(ep)) begin failures++; $display("FAIL rst_mid_restart c%0d id_pc/inst got=%h/%h exp=%h/%h", c, id_pc_o, id_inst_o, ep, rom(ep)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_single_stall();
        test_long_stall();
        test_redirect();
        test_redirect_stall();
        test_pc_wrap();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
